// File: rtl/div_pkg.sv
// Shared types and constants for the HI/LO restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: shift {R,Q} left, subtract V when it fits.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_shift = {i_rem, i_quo[WIDTH-1]};
    w_diff  = w_shift - {1'b0, i_div};
    o_rem   = w_shift[WIDTH-1:0];
    o_quo   = {i_quo[WIDTH-2:0], 1'b0};
    // The shifted remainder is below 2*V, so the extra MSB of the difference is a clean borrow.
    if (!w_diff[WIDTH]) begin
      o_rem    = w_diff[WIDTH-1:0];
      o_quo[0] = 1'b1;
    end
  end

endmodule

// File: rtl/hilo_divide_unit.sv
// Iterative DIV/DIVU unit feeding HI (remainder) and LO (quotient).
// Optional DIV_EARLY_EXIT_EN: finish in one cycle when |Dividend| < |Divisor|.
module hilo_divide_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             SignedOp,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;

  logic             w_sd;
  logic             w_sv;
  logic [WIDTH-1:0] w_abs_dd;
  logic [WIDTH-1:0] w_abs_dv;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quo;

  // Magnitudes are taken only for DIV; 0x8000_0000 stays as its unsigned magnitude.
  assign w_sd     = SignedOp & Dividend[WIDTH-1];
  assign w_sv     = SignedOp & Divisor[WIDTH-1];
  assign w_abs_dd = w_sd ? -Dividend : Dividend;
  assign w_abs_dv = w_sv ? -Divisor  : Divisor;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (Start) begin
            r_dbz <= 1'b0;
            if (Divisor == '0) begin
              r_quotient  <= '1;
              r_remainder <= Dividend;
              r_dbz       <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= DONE;
            end
`ifdef DIV_EARLY_EXIT_EN
            else if (w_abs_dd < w_abs_dv) begin
              r_quotient  <= '0;
              r_remainder <= Dividend;
              r_done      <= 1'b1;
              r_state     <= DONE;
            end
`endif
            else begin
              r_rem   <= '0;
              r_quo   <= w_abs_dd;
              r_div   <= w_abs_dv;
              r_q_neg <= w_sd ^ w_sv;
              r_r_neg <= w_sd;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_step_rem;
          r_quo <= w_step_quo;
          r_cnt <= r_cnt + CNT_W'(1);
          // Leave on the last step so FIX lands in cycle WIDTH+1 and Done in WIDTH+2.
          if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= FIX;
        end
        FIX: begin
          r_quotient  <= r_q_neg ? -r_quo : r_quo;
          r_remainder <= r_r_neg ? -r_rem : r_rem;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= DONE;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Busy      = r_busy;
  assign Done      = r_done;
  assign Quotient  = r_quotient;
  assign Remainder = r_remainder;
  assign DivByZero = r_dbz;

endmodule
